chaser_monitor: RTL
===================

Name: chaser_monitor

Overview:
Receiving end of the LED chaser interface. Samples the 8-bit walking-one pattern the chaser drives onto LED and decodes it into position, direction, frozen status and a sweep count. Flags any pattern sequence the chaser cannot legally produce. Sits beside the chaser in top, with outputs routed to SEG and the lcd_* debug signals.

Parameters:
NBITS_PISCA, 8, width of observed pattern (power of 2)
LIMITE_PARADO, 4, consecutive repeated samples before parado asserts
NBITS_VOLTAS, 8, width of sweep counter

Ports:
clk_2  in  1  clock
reset  in  1  asynchronous, active-low; all state cleared while low
padrao  in  NBITS_PISCA  observed chaser pattern
amostra  in  1  sample strobe; padrao is evaluated only in cycles where it is 1 (tie to 1 for same-clock chaser)
limpa_erro  in  1  clears sticky erro
posicao  out  $clog2(NBITS_PISCA)  index of the set bit
posicao_valida  out  1  posicao meaningful (state TRAVADO or SINC, padrao one-hot)
sentido  out  1  0 = moving right (MSB to LSB), 1 = moving left
parado  out  1  pattern frozen
erro  out  1  sticky illegal-sequence flag
voltas  out  NBITS_VOLTAS  completed sweeps, wraps modulo 2^NBITS_VOLTAS
SEG  out  8  7-segment digit of posicao (see Optional Feature)

Behaviour:
- All outputs registered. Each output reflects a sample 1 cycle after the clk_2 edge where amostra=1. With amostra=0, state and outputs hold.
- Reset values: posicao=0, posicao_valida=0, sentido=0, parado=0, erro=0, voltas=0, SEG=0, state ESPERA, previous-pattern register p=0, repeat count=0.
- Sample classes for new pattern n: ONEHOT, ZERO, BAD (2 or more bits set).
- States: ESPERA, SINC (one reference held, direction unknown), TRAVADO (direction known), ERRO.
- ESPERA:
  - ONEHOT: p<=n, go to SINC.
  - ZERO: ignored.
  - BAD: go to ERRO.
- SINC / TRAVADO, evaluated in priority order:
  1. n==p: repeat count +1, saturating at LIMITE_PARADO. parado=1 once count reaches LIMITE_PARADO.
  2. n==p>>1: sentido<=0, go to TRAVADO.
  3. n==p<<1 (within width): sentido<=1, go to TRAVADO.
  4. n==0 when p==0x01 and sentido=0, or p==0x80 and sentido=1: legal overflow gap, p<=0.
  5. p==0 and n is the reload value matching sentido (0x80 right, 0x01 left): voltas+1.
  6. p==0 and n is the opposite reload value: chaser restarted with a new direction. Set sentido from n, no voltas increment.
  7. n==0x80 or n==0x01 from any other p: chaser reset. Go to SINC, sentido<=(n==0x01), voltas unchanged.
  8. Otherwise (includes two consecutive ZERO, multi-step jump, BAD): erro<=1, go to ERRO.
- Any change of n clears the repeat count and parado. A direction flip mid-sweep (rule 2 or 3 against the current sentido) is legal and only updates sentido.
- ERRO: posicao_valida=0. Exits only on n==0x80 or n==0x01, into SINC. erro stays 1 until limpa_erro=1.
- limpa_erro clears erro on the next edge. If an error is detected in the same cycle, the error wins.
- Async reset asserted mid-operation: all outputs take their reset values immediately, without waiting for a clock edge.

Optional Feature:
CHASER_SEG_EN
- Defined: SEG shows posicao as a hex digit using the shared segment table. SEG shows "E" while erro=1 and is blank while posicao_valida=0.
- Undefined: SEG tied to 0 and the segment logic is omitted.

Decomposition:
- Package chaser_pkg: estado_t enum (ESPERA, SINC, TRAVADO, ERRO), INICIO_DIREITA=8'h80, INICIO_ESQUERDA=8'h01, 7-segment constant table.
- One sub-module, onehot_idx: combinational; outputs index, is_onehot, is_zero for padrao. Shared with future decoders.

Test Plan:
- Right sweep: reset, amostra=1, feed 80,40,20,10,08,04,02,01,00,80 -> posicao 7 down to 0, sentido=0, voltas=1 after final 80, erro=0.
- Left sweep: feed 01,02,...,80,00,01 -> sentido=1, posicao 0 up to 7, voltas=1, erro=0.
- Freeze: feed 10 for 6 samples (LIMITE_PARADO=4) -> parado=1 from the cycle after the 5th sample, then cleared 1 cycle after 08 arrives.
- Direction flip: 80,40,20,40,80 -> sentido 0 then 1 at the second 40, no erro, voltas=0.
- Illegal sequence: 20,18 -> erro=1, posicao_valida=0. Then 80 -> SINC, posicao_valida=1, erro still 1. Then limpa_erro pulse -> erro=0. Also 01,00,00 -> erro=1.
- Async reset: drop reset between edges mid-sweep -> all outputs 0 immediately. Release and feed 80 -> SINC with voltas=0.

Source files
------------

// File: rtl/chaser_pkg.sv
// chaser_pkg: shared types and constants for the LED chaser monitor.
// Segment bytes are {dp,g,f,e,d,c,b,a}, active high.
package chaser_pkg;

  typedef enum logic [1:0] {
    ESPERA,
    SINC,
    TRAVADO,
    ERRO
  } estado_t;

  typedef enum logic [1:0] {
    C_ONEHOT,
    C_ZERO,
    C_BAD
  } classe_t;

  typedef enum logic [2:0] {
    R_REPETE,
    R_DIREITA,
    R_ESQUERDA,
    R_LACUNA,
    R_VOLTA,
    R_REINICIO,
    R_RESET,
    R_ILEGAL
  } regra_t;

  localparam logic [7:0] INICIO_DIREITA  = 8'h80;
  localparam logic [7:0] INICIO_ESQUERDA = 8'h01;

  localparam logic [7:0] SEG_E       = 8'h79;
  localparam logic [7:0] SEG_APAGADO = 8'h00;

  localparam logic [7:0] SEG_HEX [16] = '{
    8'h3F, 8'h06, 8'h5B, 8'h4F,
    8'h66, 8'h6D, 8'h7D, 8'h07,
    8'h7F, 8'h6F, 8'h77, 8'h7C,
    8'h39, 8'h5E, 8'h79, 8'h71
  };

  function automatic logic [7:0] seg_digito(
    input logic [3:0] d,
    input logic       err,
    input logic       val
  );
    if (err) return SEG_E;
    if (!val) return SEG_APAGADO;
    return SEG_HEX[d];
  endfunction

endpackage

// File: rtl/onehot_idx.sv
// onehot_idx: classifies a pattern as one-hot, zero or multi-bit,
// and gives the index of the highest set bit.
module onehot_idx #(
  parameter int NBITS_PISCA = 8
) (
  input  logic [NBITS_PISCA-1:0]         padrao,
  output logic [$clog2(NBITS_PISCA)-1:0] index,
  output logic                           is_onehot,
  output logic                           is_zero
);

  localparam int PW = $clog2(NBITS_PISCA);

  always_comb begin
    index = '0;
    for (int i = 0; i < NBITS_PISCA; i++) begin
      if (padrao[i]) index = PW'(i);
    end
  end

  assign is_zero = (padrao == '0);

  assign is_onehot = !is_zero &&
    ((padrao & (padrao - NBITS_PISCA'(1))) == '0);

endmodule

// File: rtl/chaser_monitor.sv
// chaser_monitor: decodes the chaser walking-one pattern into position,
// direction, freeze, sweep count and sticky error. CHASER_SEG_EN drives SEG.
import chaser_pkg::*;

module chaser_monitor #(
  parameter int NBITS_PISCA   = 8,
  parameter int LIMITE_PARADO = 4,
  parameter int NBITS_VOLTAS  = 8
) (
  input  logic                           clk_2,
  input  logic                           reset,
  input  logic [NBITS_PISCA-1:0]         padrao,
  input  logic                           amostra,
  input  logic                           limpa_erro,
  output logic [$clog2(NBITS_PISCA)-1:0] posicao,
  output logic                           posicao_valida,
  output logic                           sentido,
  output logic                           parado,
  output logic                           erro,
  output logic [NBITS_VOLTAS-1:0]        voltas,
  output logic [7:0]                     SEG
);

  localparam int PW = $clog2(NBITS_PISCA);
  localparam int CW = $clog2(LIMITE_PARADO + 1);
  localparam logic [CW-1:0] LIM_C = CW'(LIMITE_PARADO);

  localparam logic [NBITS_PISCA-1:0] INI_D =
    (NBITS_PISCA == 8) ? INICIO_DIREITA
                       : {1'b1, {(NBITS_PISCA-1){1'b0}}};
  localparam logic [NBITS_PISCA-1:0] INI_E =
    (NBITS_PISCA == 8) ? INICIO_ESQUERDA
                       : NBITS_PISCA'(1);

  estado_t                 estado_q, estado_d;
  logic [NBITS_PISCA-1:0]  p_q, p_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    sentido_q, sentido_d;
  logic                    parado_q, parado_d;
  logic                    erro_q, erro_d;
  logic [NBITS_VOLTAS-1:0] voltas_q, voltas_d;
  logic [PW-1:0]           posicao_q, posicao_d;
  logic                    posicao_valida_q, posicao_valida_d;
  logic                    erro_set;

  logic [PW-1:0] n_idx;
  logic          n_one;
  logic          n_zero;
  logic          n_ini;
  logic          fim_ok;
  logic [NBITS_PISCA-1:0] alvo;
  logic [NBITS_PISCA-1:0] oposto;
  classe_t       classe;
  regra_t        regra;

  onehot_idx #(
    .NBITS_PISCA (NBITS_PISCA)
  ) u_idx (
    .padrao    (padrao),
    .index     (n_idx),
    .is_onehot (n_one),
    .is_zero   (n_zero)
  );

  assign n_ini  = (padrao == INI_D) || (padrao == INI_E);
  assign fim_ok = sentido_q ? (p_q == INI_D) : (p_q == INI_E);
  assign alvo   = sentido_q ? INI_E : INI_D;
  assign oposto = sentido_q ? INI_D : INI_E;

  always_comb begin
    classe = C_BAD;
    if (n_one) classe = C_ONEHOT;
    else if (n_zero) classe = C_ZERO;
  end

  // First matching rule wins; a repeated zero is never a repeat.
  always_comb begin
    regra = R_ILEGAL;
    if (!n_zero && padrao == p_q)
      regra = R_REPETE;
    else if (n_one && padrao == (p_q >> 1))
      regra = R_DIREITA;
    else if (n_one && padrao == (p_q << 1))
      regra = R_ESQUERDA;
    else if (n_zero && fim_ok)
      regra = R_LACUNA;
    else if (p_q == '0 && padrao == alvo)
      regra = R_VOLTA;
    else if (p_q == '0 && padrao == oposto)
      regra = R_REINICIO;
    else if (n_ini)
      regra = R_RESET;
  end

  always_comb begin
    estado_d         = estado_q;
    p_d              = p_q;
    cnt_d            = cnt_q;
    sentido_d        = sentido_q;
    parado_d         = parado_q;
    voltas_d         = voltas_q;
    posicao_d        = posicao_q;
    posicao_valida_d = posicao_valida_q;
    erro_set         = 1'b0;
    if (amostra) begin
      unique case (estado_q)
        ESPERA: begin
          unique case (classe)
            C_ONEHOT: begin
              p_d      = padrao;
              estado_d = SINC;
            end
            C_BAD: begin
              estado_d = ERRO;
              erro_set = 1'b1;
            end
            default: ;
          endcase
        end
        ERRO: begin
          cnt_d = '0;
          if (n_ini) begin
            estado_d  = SINC;
            p_d       = padrao;
            sentido_d = (padrao == INI_E);
          end
        end
        SINC, TRAVADO: begin
          cnt_d = '0;
          unique case (regra)
            R_REPETE: begin
              cnt_d = (cnt_q == LIM_C) ? cnt_q
                                       : cnt_q + CW'(1);
            end
            R_DIREITA: begin
              sentido_d = 1'b0;
              estado_d  = TRAVADO;
              p_d       = padrao;
            end
            R_ESQUERDA: begin
              sentido_d = 1'b1;
              estado_d  = TRAVADO;
              p_d       = padrao;
            end
            R_LACUNA: begin
              p_d = '0;
            end
            R_VOLTA: begin
              voltas_d = voltas_q + NBITS_VOLTAS'(1);
              p_d      = padrao;
            end
            R_REINICIO: begin
              sentido_d = (padrao == INI_E);
              p_d       = padrao;
            end
            R_RESET: begin
              estado_d  = SINC;
              sentido_d = (padrao == INI_E);
              p_d       = padrao;
            end
            R_ILEGAL: begin
              estado_d = ERRO;
              erro_set = 1'b1;
            end
          endcase
        end
      endcase
      parado_d = (cnt_d == LIM_C);
      posicao_valida_d = n_one &&
        (estado_d == SINC || estado_d == TRAVADO);
      if (n_one) posicao_d = n_idx;
    end
  end

  // A freshly detected error beats a simultaneous clear.
  assign erro_d = erro_set | (erro_q & ~limpa_erro);

  always_ff @(posedge clk_2 or negedge reset) begin
    if (!reset) begin
      estado_q         <= ESPERA;
      p_q              <= '0;
      cnt_q            <= '0;
      sentido_q        <= 1'b0;
      parado_q         <= 1'b0;
      erro_q           <= 1'b0;
      voltas_q         <= '0;
      posicao_q        <= '0;
      posicao_valida_q <= 1'b0;
    end else begin
      estado_q         <= estado_d;
      p_q              <= p_d;
      cnt_q            <= cnt_d;
      sentido_q        <= sentido_d;
      parado_q         <= parado_d;
      erro_q           <= erro_d;
      voltas_q         <= voltas_d;
      posicao_q        <= posicao_d;
      posicao_valida_q <= posicao_valida_d;
    end
  end

  assign posicao        = posicao_q;
  assign posicao_valida = posicao_valida_q;
  assign sentido        = sentido_q;
  assign parado         = parado_q;
  assign erro           = erro_q;
  assign voltas         = voltas_q;

`ifdef CHASER_SEG_EN
  logic [7:0] seg_d, seg_q;

  always_comb begin
    seg_d = seg_digito(4'(posicao_d), erro_d,
                       posicao_valida_d);
  end

  always_ff @(posedge clk_2 or negedge reset) begin
    if (!reset) seg_q <= '0;
    else        seg_q <= seg_d;
  end

  assign SEG = seg_q;
`else
  assign SEG = 8'h00;
`endif

endmodule
